// File: rtl/mem_io_responder.sv
// mem_io_responder
// Byte-wide memory and I/O responder for a simple CPU bus. Addresses whose
// bits 17:16 are 2'b11 select the I/O window; everything else maps onto a
// 2^RAM_AW byte RAM. Reads are registered (one cycle of latency) and the
// returned byte holds until the next read request. The I/O window provides
// an RX input byte port, a TX output FIFO, a free-running cycle counter with
// a tear-free snapshot, and a sticky halt flag.
//
// Ports:
//   clk_in    - sole clock, rising edge
//   rst_in    - asynchronous active-high reset
//   mem_a     - CPU address (only bits 17:0 decoded)
//   mem_wr    - 1 = write, 0 = read request
//   mem_dout  - CPU write data
//   mem_din   - registered read data back to the CPU
//   rx_valid  - input byte available
//   rx_data   - input byte
//   rx_ready  - pop pulse for the input byte (same cycle as the read)
//   tx_valid  - TX FIFO non-empty
//   tx_data   - TX FIFO head byte
//   tx_ready  - sink accepts tx_data when tx_valid is also high
//   io_busy   - TX FIFO full (used externally to stall the CPU)
//   halt      - sticky program-stop flag
module mem_io_responder #(
  parameter int RAM_AW    = 17,
  parameter int TXQ_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        io_busy,
  output logic        halt
);

  localparam int PW = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [7:0]    ram [0:(2**RAM_AW)-1];
  logic [7:0]    txq [0:TXQ_DEPTH-1];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   counter;
  logic [31:0]   snapshot;

  logic          io_sel;
  logic          is_rx;
  logic          is_ctr;
  logic          is_snap;
  logic          rd_req;
  logic [7:0]    rd_data;
  logic          push_req;
  logic [7:0]    push_byte;
  logic          push_ok;
  logic          pop;
  logic          full;
  logic          unused_addr;

  // Upper address bits are intentionally not decoded.
  assign unused_addr = &{1'b0, mem_a[31:18]};

  assign io_sel  = (mem_a[17:16] == 2'b11);
  assign is_rx   = io_sel && (mem_a[15:0] == 16'h0000);
  assign is_ctr  = io_sel && (mem_a[15:0] == 16'h0004);
  assign is_snap = io_sel && (mem_a[15:2] == 14'h0001) && (mem_a[1:0] != 2'b00);
  assign rd_req  = !mem_wr;

  // The RX pop is combinational so the source sees it in the request cycle;
  // it is masked during reset so no byte is lost while the core is held.
  assign rx_ready = rd_req && is_rx && rx_valid && !rst_in;

  assign full     = (count == CW'(TXQ_DEPTH));
  assign io_busy  = full;
  assign tx_valid = (count != '0);
  assign tx_data  = txq[rd_ptr];
  assign pop      = tx_ready && tx_valid;

  // A halt write always enqueues 0x00 as an end-of-program marker, while a
  // data-port write of 0x00 is treated as a no-op.
  always_comb begin
    push_req  = 1'b0;
    push_byte = mem_dout;
    if (mem_wr && is_ctr) begin
      push_req  = 1'b1;
      push_byte = 8'h00;
    end else if (mem_wr && is_rx && (mem_dout != 8'h00)) begin
      push_req  = 1'b1;
    end
  end

  // A push into a full FIFO still succeeds if the head leaves in the same cycle.
  assign push_ok = push_req && (!full || pop);

  // Read data selection; unmapped I/O addresses read as zero.
  always_comb begin
    rd_data = 8'h00;
    if (!io_sel) begin
      rd_data = ram[mem_a[RAM_AW-1:0]];
    end else if (is_rx) begin
      rd_data = rx_valid ? rx_data : 8'h00;
    end else if (is_ctr) begin
      rd_data = counter[7:0];
    end else if (is_snap) begin
      case (mem_a[1:0])
        2'b01:   rd_data = snapshot[15:8];
        2'b10:   rd_data = snapshot[23:16];
        default: rd_data = snapshot[31:24];
      endcase
    end
  end

  // RAM contents survive reset, so this array has no reset branch.
  always_ff @(posedge clk_in) begin
    if (mem_wr && !io_sel) begin
      ram[mem_a[RAM_AW-1:0]] <= mem_dout;
    end
  end

  // FIFO storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      txq[wr_ptr] <= push_byte;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Read data is captured only on read requests, so it holds across writes.
  // Reading the low counter byte captures the whole counter so the upper
  // bytes can be fetched later without tearing.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mem_din  <= 8'h00;
      snapshot <= 32'h0;
    end else if (rd_req) begin
      mem_din <= rd_data;
      if (is_ctr) snapshot <= counter;
    end
  end

  // Counter freezes once halted; halt is sticky until reset.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      counter <= 32'h0;
      halt    <= 1'b0;
    end else begin
      if (!halt)            counter <= counter + 32'd1;
      if (mem_wr && is_ctr) halt    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder
// Scoreboard bench for mem_io_responder. The stimulus process drives one bus
// cycle at a time, updates a behavioural model (byte map for RAM, queue for
// the TX FIFO, plain counters) and pushes expected read bytes and TX bytes
// into queues. A monitor on the falling edge pops and compares whenever the
// DUT presents read data or a TX handshake, and checks the status flags.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [31:0] mem_a = 32'h0003_000C;
  logic        mem_wr = 1'b1;
  logic [7:0]  mem_dout = 8'h00;
  logic [7:0]  mem_din;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        io_busy;
  logic        halt;

  mem_io_responder #(.RAM_AW(17), .TXQ_DEPTH(4)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .mem_a    (mem_a),
    .mem_wr   (mem_wr),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .io_busy  (io_busy),
    .halt     (halt)
  );

  always #5 clk_in = ~clk_in;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state
  logic [7:0]  read_q [$];
  logic [7:0]  tx_exp [$];
  logic [7:0]  ram_m [int];
  int          occ = 0;
  logic [31:0] cnt_m = 32'h0;
  logic [31:0] snap_m = 32'h0;
  logic        halt_m = 1'b0;
  logic        exp_rx_ready = 1'b0;
  logic [7:0]  last_exp = 8'h00;
  logic        prev_read = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportMissing(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: DUT produced output but scoreboard queue empty at %0t", name, $time);
  endtask

  // Monitor: read data appears one cycle after a read request.
  always @(negedge clk_in) begin
    if (rst_in) begin
      prev_read = 1'b0;
    end else begin
      if (prev_read) begin
        if (read_q.size() == 0) reportMissing("read_q");
        else last_exp = read_q.pop_front();
      end
      checkOutput("mem_din", {24'h0, mem_din}, {24'h0, last_exp});
      checkOutput("rx_ready", {31'h0, rx_ready}, {31'h0, exp_rx_ready});
      checkOutput("tx_valid", {31'h0, tx_valid}, {31'h0, (occ != 0)});
      checkOutput("io_busy", {31'h0, io_busy}, {31'h0, (occ == 4)});
      checkOutput("halt", {31'h0, halt}, {31'h0, halt_m});
      if (tx_valid && tx_ready) begin
        if (tx_exp.size() == 0) reportMissing("tx_exp");
        else checkOutput("tx_data", {24'h0, tx_data}, {24'h0, tx_exp.pop_front()});
      end
      prev_read = !mem_wr;
    end
  end

  // Drives one bus cycle starting at posedge+2 and applies the model's
  // view of that cycle at the following rising edge.
  task automatic applyStimulus(input logic [31:0] a, input logic wr, input logic [7:0] dout,
                               input logic rxv, input logic [7:0] rxd, input logic txr);
    logic [17:0] off;
    logic        io;
    logic [7:0]  v;
    logic        push;
    logic [7:0]  pb;
    logic        snap_upd;
    logic        pop_m;
    off      = a[17:0];
    io       = (a[17:16] == 2'b11);
    push     = 1'b0;
    pb       = 8'h00;
    snap_upd = 1'b0;
    v        = 8'h00;
    mem_a    = a;
    mem_wr   = wr;
    mem_dout = dout;
    rx_valid = rxv;
    rx_data  = rxd;
    tx_ready = txr;
    exp_rx_ready = !wr && (off == 18'h30000) && rxv;
    if (!wr) begin
      if (!io) begin
        v = ram_m.exists(int'(a[16:0])) ? ram_m[int'(a[16:0])] : 8'h00;
      end else begin
        case (off)
          18'h30000: v = rxv ? rxd : 8'h00;
          18'h30004: begin v = cnt_m[7:0]; snap_upd = 1'b1; end
          18'h30005: v = snap_m[15:8];
          18'h30006: v = snap_m[23:16];
          18'h30007: v = snap_m[31:24];
          default:   v = 8'h00;
        endcase
      end
      read_q.push_back(v);
    end else if (io) begin
      if (off == 18'h30004) begin push = 1'b1; pb = 8'h00; end
      else if (off == 18'h30000 && dout != 8'h00) begin push = 1'b1; pb = dout; end
    end
    @(posedge clk_in);
    pop_m = txr && (occ > 0);
    if (push && (occ < 4 || pop_m)) begin
      tx_exp.push_back(pb);
      occ++;
    end
    if (pop_m) occ--;
    if (wr && !io) ram_m[int'(a[16:0])] = dout;
    if (snap_upd) snap_m = cnt_m;
    if (!halt_m) cnt_m = cnt_m + 32'd1;
    if (wr && off == 18'h30004) halt_m = 1'b1;
    #2;
  endtask

  task automatic idle(input int n, input logic txr);
    for (int i = 0; i < n; i++) applyStimulus(32'h0003_000C, 1'b1, 8'h00, 1'b0, 8'h00, txr);
  endtask

  // Asserts reset mid-cycle (with an RX read pending) and checks that all
  // outputs clear immediately, then releases reset after two edges.
  task automatic doReset();
    mem_wr   = 1'b0;
    mem_a    = 32'h0003_0000;
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    tx_ready = 1'b0;
    rst_in   = 1'b1;
    #1;
    checkOutput("rst_mem_din", {24'h0, mem_din}, 32'h0);
    checkOutput("rst_rx_ready", {31'h0, rx_ready}, 32'h0);
    checkOutput("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    checkOutput("rst_io_busy", {31'h0, io_busy}, 32'h0);
    checkOutput("rst_halt", {31'h0, halt}, 32'h0);
    read_q.delete();
    tx_exp.delete();
    occ = 0;
    cnt_m = 32'h0;
    snap_m = 32'h0;
    halt_m = 1'b0;
    last_exp = 8'h00;
    exp_rx_ready = 1'b0;
    @(posedge clk_in);
    @(posedge clk_in);
    #2;
    mem_wr   = 1'b1;
    mem_a    = 32'h0003_000C;
    rx_valid = 1'b0;
    rst_in   = 1'b0;
  endtask

  initial begin
    logic [7:0]  tx_list [6];
    logic [17:0] io_rd [7];
    logic [17:0] io_wr [3];
    logic [31:0] up;
    int          r;
    int          i;
    int          guard;
    tx_list = '{8'h31, 8'h00, 8'h32, 8'h33, 8'h34, 8'h35};
    io_rd   = '{18'h30000, 18'h30004, 18'h30005, 18'h30006, 18'h30007, 18'h30008, 18'h3FFFF};
    io_wr   = '{18'h30008, 18'h30005, 18'h3FFFF};

    @(posedge clk_in);
    #2;
    doReset();

    // RAM write then read-back
    applyStimulus(32'h0000_0100, 1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
    applyStimulus(32'h0000_0100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    idle(1, 1'b0);

    // RX port with and without a byte available
    applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b1, 8'h41, 1'b0);
    applyStimulus(32'h0003_0000, 1'b0, 8'h00, 1'b0, 8'h55, 1'b0);
    idle(1, 1'b0);

    // Seed the RAM addresses used by the random phase
    for (int k = 0; k < 16; k++)
      applyStimulus({14'h0, 18'(k * 18'h2A5F)}, 1'b1, 8'($urandom), 1'b0, 8'h00, 1'b0);

    // TX fill with sink stalled, then drain
    foreach (tx_list[k]) applyStimulus(32'h0003_0000, 1'b1, tx_list[k], 1'b0, 8'h00, 1'b0);
    idle(6, 1'b1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 9);
      up = $urandom;
      if (r <= 4) begin
        i = $urandom_range(0, 15);
        applyStimulus({up[31:18], 18'(i * 18'h2A5F)}, 1'($urandom), 8'($urandom),
                      1'($urandom), 8'($urandom), $urandom_range(0, 2) != 0);
      end else if (r <= 7) begin
        applyStimulus({up[31:18], io_rd[$urandom_range(0, 6)]}, 1'b0, 8'($urandom),
                      1'($urandom), 8'($urandom), $urandom_range(0, 2) != 0);
      end else if (r == 8) begin
        applyStimulus({up[31:18], 18'h30000}, 1'b1,
                      ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom),
                      1'($urandom), 8'($urandom), $urandom_range(0, 2) != 0);
      end else begin
        applyStimulus({up[31:18], io_wr[$urandom_range(0, 2)]}, 1'b1, 8'($urandom),
                      1'($urandom), 8'($urandom), $urandom_range(0, 2) != 0);
      end
    end
    idle(8, 1'b1);
    checkOutput("tx_drained", tx_exp.size(), 32'h0);

    // Counter snapshot at 0x1234
    doReset();
    guard = 0;
    while (cnt_m != 32'h0000_1234 && guard < 10000) begin
      idle(1, 1'b0);
      guard++;
    end
    checkOutput("counter_reach", cnt_m, 32'h0000_1234);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(32'h0003_0005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(32'h0003_0006, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(32'h0003_0007, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    idle(1, 1'b0);

    // Halt: 0x00 marker, frozen counter, writes still serviced
    applyStimulus(32'h0003_0004, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0);
    idle(2, 1'b1);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    idle(3, 1'b0);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    applyStimulus(32'h0003_0000, 1'b1, 8'h61, 1'b0, 8'h00, 1'b0);
    applyStimulus(32'h0003_0000, 1'b1, 8'h62, 1'b0, 8'h00, 1'b0);
    applyStimulus(32'h0003_0004, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Reset mid-stream, then confirm snapshot cleared and RAM retained
    doReset();
    applyStimulus(32'h0003_0005, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    applyStimulus(32'h0000_0100, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    idle(3, 1'b1);
    checkOutput("read_q_empty", read_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
